fpcmult_dot_vrtl: RTL

//  Parametrised fixed-point complex multiply-accumulate engine. Computes
//  c = sum_k a_k * b_k, or sum_k a_k * conj(b_k), over a vector of complex

---
 rtl/fpcmult_dot_vrtl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fpcmult_dot_vrtl.sv
// fpcmult_dot_vrtl
// Fixed-point complex multiply-accumulate engine. Streams complex elements
// (a_k, b_k) with a last flag and produces c = sum a_k * b_k, or
// sum a_k * conj(b_k) when conj is set on the first element of the vector.
// Each element is multiplied by four parallel shift-add units (one multiplier
// bit per cycle), then accumulated with optional saturation.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   recv_val   input element valid
//   recv_rdy   block can accept an element (registered)
//   recv_last  element is the last of the vector
//   conj       use conj(b); taken from the first element of a vector only
//   ar, ac     operand a real / imaginary (Q(n-d).d)
//   br, bc     operand b real / imaginary (Q(n-d).d)
//   send_val   result valid (registered)
//   send_rdy   consumer accepts the result
//   cr, cc     accumulated result real / imaginary (registered)
//
// State | meaning
// IDLE  | waiting for an element; recv_rdy high
// MUL   | n shift-add steps of the four partial products
// ACC   | add the element's product into the accumulators
// SEND  | result presented; first cycle raises send_val, then waits for send_rdy
module fpcmult_dot_vrtl #(
    parameter int n   = 32,
    parameter int d   = 16,
    parameter int sat = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic         recv_last,
    input  logic         conj,
    input  logic [n-1:0] ar,
    input  logic [n-1:0] ac,
    input  logic [n-1:0] br,
    input  logic [n-1:0] bc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] cr,
    output logic [n-1:0] cc
);

    localparam int cw = $clog2(n);

    typedef enum logic [1:0] {IDLE, MUL, ACC, SEND} state_t;

    state_t           state;
    logic [cw-1:0]    count;
    logic             last_q;
    logic             first;
    logic             conj_q;

    // Multiplicands are sign-extended to 2n bits and shifted left; multipliers
    // are shifted right so bit 0 is always the current multiplier bit.
    logic [2*n-1:0]   ar_sh;
    logic [2*n-1:0]   ac_sh;
    logic [n-1:0]     br_sh;
    logic [n-1:0]     bc_sh;

    logic [2*n-1:0]   p_rr;   // ar * br
    logic [2*n-1:0]   p_ii;   // ac * bc'
    logic [2*n-1:0]   p_ri;   // ar * bc'
    logic [2*n-1:0]   p_ir;   // ac * br

    logic [n-1:0]     accr;
    logic [n-1:0]     accc;

    logic             conj_use;
    logic [n-1:0]     bc_eff;
    logic             sign_step;
    logic [n-1:0]     pr;
    logic [n-1:0]     pc;
    logic [n-1:0]     accr_nxt;
    logic [n-1:0]     accc_nxt;
    logic             unused_bits;

    // Two's-complement shift-add step; the multiplier sign bit has weight
    // -2^(n-1), so the last step subtracts instead of adding.
    function automatic logic [2*n-1:0] step(input logic [2*n-1:0] p,
                                            input logic [2*n-1:0] x,
                                            input logic           b,
                                            input logic           neg);
        logic [2*n-1:0] addend;
        addend = b ? x : '0;
        return neg ? (p - addend) : (p + addend);
    endfunction

    function automatic logic [n-1:0] acc_add(input logic [n-1:0] a,
                                             input logic [n-1:0] b);
        logic [n-1:0] s;
        s = a + b;
        if (sat != 0 && a[n-1] == b[n-1] && s[n-1] != a[n-1])
            return a[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        return s;
    endfunction

    // conj is only honoured on the first element; later elements reuse the latch.
    assign conj_use  = first ? conj : conj_q;
    assign bc_eff    = conj_use ? (~bc + 1'b1) : bc;
    assign sign_step = (count == cw'(n - 1));

    assign pr = p_rr[n+d-1:d] - p_ii[n+d-1:d];
    assign pc = p_ri[n+d-1:d] + p_ir[n+d-1:d];

    assign accr_nxt = acc_add(accr, pr);
    assign accc_nxt = acc_add(accc, pc);

    // Bits outside the truncation window only serve as carries.
    assign unused_bits = ^{p_rr[2*n-1:n+d], p_rr[d-1:0],
                           p_ii[2*n-1:n+d], p_ii[d-1:0],
                           p_ri[2*n-1:n+d], p_ri[d-1:0],
                           p_ir[2*n-1:n+d], p_ir[d-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            last_q   <= 1'b0;
            first    <= 1'b1;
            conj_q   <= 1'b0;
            ar_sh    <= '0;
            ac_sh    <= '0;
            br_sh    <= '0;
            bc_sh    <= '0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            accr     <= '0;
            accc     <= '0;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
            cr       <= '0;
            cc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (recv_val && recv_rdy) begin
                        ar_sh    <= {{n{ar[n-1]}}, ar};
                        ac_sh    <= {{n{ac[n-1]}}, ac};
                        br_sh    <= br;
                        bc_sh    <= bc_eff;
                        p_rr     <= '0;
                        p_ii     <= '0;
                        p_ri     <= '0;
                        p_ir     <= '0;
                        last_q   <= recv_last;
                        if (first) begin
                            conj_q <= conj;
                            first  <= 1'b0;
                        end
                        count    <= '0;
                        recv_rdy <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    p_rr  <= step(p_rr, ar_sh, br_sh[0], sign_step);
                    p_ii  <= step(p_ii, ac_sh, bc_sh[0], sign_step);
                    p_ri  <= step(p_ri, ar_sh, bc_sh[0], sign_step);
                    p_ir  <= step(p_ir, ac_sh, br_sh[0], sign_step);
                    ar_sh <= ar_sh << 1;
                    ac_sh <= ac_sh << 1;
                    br_sh <= br_sh >> 1;
                    bc_sh <= bc_sh >> 1;
                    count <= count + cw'(1);
                    if (sign_step)
                        state <= ACC;
                end
                ACC: begin
                    accr <= accr_nxt;
                    accc <= accc_nxt;
                    if (last_q) begin
                        cr    <= accr_nxt;
                        cc    <= accc_nxt;
                        state <= SEND;
                    end else begin
                        recv_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                SEND: begin
                    // cr/cc were loaded in ACC; send_val follows one cycle later.
                    if (!send_val) begin
                        send_val <= 1'b1;
                    end else if (send_rdy) begin
                        send_val <= 1'b0;
                        accr     <= '0;
                        accc     <= '0;
                        first    <= 1'b1;
                        recv_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
